pc_sequencer: RTL and testbench

Fetch-side control block that decides, every cycle, whether the PC register advances, holds, or is redirected, and what next-PC value it loads. It sits between the hazard/branch logic in ID, the cache stall lines, and the PC register. It drives that register's pc_i, pcEnable_i and stall_i inputs, plus the IF/ID and ID/EX pipeline-register controls. It also sequences a post-start boot window, buffers a branch redirect that arrives during a memory stall, and keeps a saturating stall-cycle counter.

---
 rtl/pc_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: picks advance / hold / redirect for the PC register
// each cycle. It also runs a post-start boot window, buffers a branch redirect
// that arrives while a cache stall is in progress, and counts stall/bubble cycles.
// Ports:
//   clk_i, rst_i (async, active low)
//   start_i                        run enable (low = halted)
//   pc_i                           current PC from the PC register
//   icache_stall_i, dcache_stall_i memory not-ready lines
//   load_use_i                     load-use hazard in ID
//   branch_taken_i, branch_target_i resolved redirect from ID
//   pc_next_o, pc_enable_o, stall_o  PC register controls (combinational)
//   ifid_write_o, ifid_flush_o, idex_bubble_o  pipeline register controls
//   stall_cnt_o                    saturating stall/bubble cycle count
//   state_o                        debug: 00 OFF, 01 BOOT, 10 RUN, 11 WAIT
module pc_sequencer #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      pc_i,
  input  logic             icache_stall_i,
  input  logic             dcache_stall_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  output logic [31:0]      pc_next_o,
  output logic             pc_enable_o,
  output logic             stall_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [1:0]       state_o
);

  localparam int unsigned BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int unsigned BOOT_LAST = (BOOT_CYCLES == 0) ? 0 : BOOT_CYCLES - 1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_BOOT = 2'b01,
    ST_RUN  = 2'b10,
    ST_WAIT = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
  logic             pend_v_q, pend_v_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] pc_inc;
  logic        mem_stall;
  logic        off_out;
  logic        stall_out;
  logic        run_out;
  logic        count_en;

  assign pc_inc    = pc_i + 32'd4;
  assign mem_stall = icache_stall_i | dcache_stall_i;

  // State and bookkeeping registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_OFF;
      boot_cnt_q  <= '0;
      pend_v_q    <= 1'b0;
      pend_tgt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pend_v_q    <= pend_v_d;
      pend_tgt_q  <= pend_tgt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state, pending-branch capture and combinational fetch controls
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pend_v_d      = pend_v_q;
    pend_tgt_d    = pend_tgt_q;
    stall_cnt_d   = stall_cnt_q;
    pc_next_o     = pc_inc;
    pc_enable_o   = 1'b0;
    stall_o       = 1'b0;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    off_out       = 1'b0;
    stall_out     = 1'b0;
    run_out       = 1'b0;
    count_en      = 1'b0;

    if (!start_i) begin
      off_out    = 1'b1;
      state_d    = ST_OFF;
      pend_v_d   = 1'b0;
      boot_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          off_out    = 1'b1;
          boot_cnt_d = '0;
          state_d    = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;
        end
        ST_BOOT: begin
          pc_next_o     = RESET_PC;
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b1;
          if (boot_cnt_q == BW'(BOOT_LAST)) begin
            state_d = ST_RUN;
          end else begin
            boot_cnt_d = boot_cnt_q + BW'(1);
          end
        end
        ST_RUN: begin
          count_en = 1'b1;
          if (mem_stall) begin
            stall_out = 1'b1;
            state_d   = ST_WAIT;
            if (branch_taken_i) begin
              pend_v_d   = 1'b1;
              pend_tgt_d = branch_target_i;
            end
          end else begin
            run_out = 1'b1;
          end
        end
        ST_WAIT: begin
          count_en = 1'b1;
          if (mem_stall) begin
            stall_out = 1'b1;
            // First captured target wins; later redirects are dropped
            if (branch_taken_i && !pend_v_q) begin
              pend_v_d   = 1'b1;
              pend_tgt_d = branch_target_i;
            end
          end else begin
            state_d = ST_RUN;
            if (pend_v_q) begin
              pc_next_o    = pend_tgt_q;
              pc_enable_o  = 1'b1;
              ifid_flush_o = 1'b1;
              pend_v_d     = 1'b0;
            end else begin
              run_out = 1'b1;
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    if (off_out) begin
      pc_next_o     = RESET_PC;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end

    if (stall_out) begin
      stall_o      = 1'b1;
      ifid_write_o = 1'b0;
    end

    // Normal RUN priorities below the cache stall
    if (run_out) begin
      if (load_use_i) begin
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
        pc_next_o    = branch_target_i;
        pc_enable_o  = 1'b1;
        ifid_flush_o = 1'b1;
      end else begin
        pc_enable_o = 1'b1;
      end
    end

    if (count_en && (stall_o || idex_bubble_o) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, load-use, branch, buffered redirect,
// counter saturation (CNT_W=4 instance) and halt/restart.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        icache_stall_i;
  logic        dcache_stall_i;
  logic        load_use_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;

  logic [31:0] pc_next_o;
  logic        pc_enable_o;
  logic        stall_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic [15:0] stall_cnt_o;
  logic [1:0]  state_o;

  logic [31:0] s_pc_next_o;
  logic        s_pc_enable_o;
  logic        s_stall_o;
  logic        s_ifid_write_o;
  logic        s_ifid_flush_o;
  logic        s_idex_bubble_o;
  logic [3:0]  s_stall_cnt_o;
  logic [1:0]  s_state_o;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(.BOOT_CYCLES(2), .RESET_PC(32'h0), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .icache_stall_i(icache_stall_i), .dcache_stall_i(dcache_stall_i),
    .load_use_i(load_use_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i), .pc_next_o(pc_next_o),
    .pc_enable_o(pc_enable_o), .stall_o(stall_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
    .stall_cnt_o(stall_cnt_o), .state_o(state_o)
  );

  pc_sequencer #(.BOOT_CYCLES(2), .RESET_PC(32'h0), .CNT_W(4)) u_dut_sat (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .icache_stall_i(icache_stall_i), .dcache_stall_i(dcache_stall_i),
    .load_use_i(load_use_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i), .pc_next_o(s_pc_next_o),
    .pc_enable_o(s_pc_enable_o), .stall_o(s_stall_o), .ifid_write_o(s_ifid_write_o),
    .ifid_flush_o(s_ifid_flush_o), .idex_bubble_o(s_idex_bubble_o),
    .stall_cnt_o(s_stall_cnt_o), .state_o(s_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point in the middle of the current cycle
  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; pc_i = '0;
    icache_stall_i = 1'b0; dcache_stall_i = 1'b0; load_use_i = 1'b0;
    branch_taken_i = 1'b0; branch_target_i = '0;

    #12;
    check("rst_state", 32'(state_o), 32'h0);
    check("rst_cnt", 32'(stall_cnt_o), 32'h0);
    check("rst_pc_en", 32'(pc_enable_o), 32'h0);
    check("rst_flush", 32'(ifid_flush_o), 32'h1);
    check("rst_bubble", 32'(idex_bubble_o), 32'h1);
    rst_i = 1'b1;
    tick();

    // Boot sequence: OFF, BOOT, BOOT, RUN
    start_i = 1'b1; pc_i = 32'h0;
    sample();
    check("c0_state", 32'(state_o), 32'h0);
    check("c0_pc_en", 32'(pc_enable_o), 32'h0);
    check("c0_pc_next", pc_next_o, 32'h0);
    tick();
    sample();
    check("c1_state", 32'(state_o), 32'h1);
    check("c1_pc_en", 32'(pc_enable_o), 32'h0);
    check("c1_flush", 32'(ifid_flush_o), 32'h1);
    tick();
    icache_stall_i = 1'b1;
    sample();
    check("c2_state", 32'(state_o), 32'h1);
    check("boot_ignores_stall", 32'(stall_o), 32'h0);
    tick();
    icache_stall_i = 1'b0;
    sample();
    check("c3_state", 32'(state_o), 32'h2);
    check("c3_pc_en", 32'(pc_enable_o), 32'h1);
    check("c3_pc_next", pc_next_o, 32'h4);
    check("c3_cnt", 32'(stall_cnt_o), 32'h0);
    tick();

    // Load-use bubble
    pc_i = 32'h100; load_use_i = 1'b1;
    sample();
    check("lu_pc_en", 32'(pc_enable_o), 32'h0);
    check("lu_bubble", 32'(idex_bubble_o), 32'h1);
    check("lu_ifid_wr", 32'(ifid_write_o), 32'h0);
    check("lu_stall", 32'(stall_o), 32'h0);
    tick();
    load_use_i = 1'b0;
    sample();
    check("lu_next_pc", pc_next_o, 32'h104);
    check("lu_next_en", 32'(pc_enable_o), 32'h1);
    check("lu_cnt", 32'(stall_cnt_o), 32'h1);
    tick();

    // Taken branch redirect
    pc_i = 32'h200; branch_taken_i = 1'b1; branch_target_i = 32'h80;
    sample();
    check("br_pc_next", pc_next_o, 32'h80);
    check("br_pc_en", 32'(pc_enable_o), 32'h1);
    check("br_flush", 32'(ifid_flush_o), 32'h1);
    tick();

    // dcache stall 5 cycles with branch in cycle 1, later branch ignored
    pc_i = 32'h3C4; dcache_stall_i = 1'b1; branch_target_i = 32'h3C0;
    for (int i = 1; i <= 5; i++) begin
      branch_taken_i = (i == 1) || (i == 3);
      branch_target_i = (i == 3) ? 32'h500 : 32'h3C0;
      sample();
      check($sformatf("ds_stall_%0d", i), 32'(stall_o), 32'h1);
      check($sformatf("ds_pc_en_%0d", i), 32'(pc_enable_o), 32'h0);
      check($sformatf("ds_ifid_wr_%0d", i), 32'(ifid_write_o), 32'h0);
      tick();
    end
    dcache_stall_i = 1'b0; branch_taken_i = 1'b0;
    sample();
    check("ds_state_wait", 32'(state_o), 32'h3);
    check("ds_redirect_pc", pc_next_o, 32'h3C0);
    check("ds_redirect_en", 32'(pc_enable_o), 32'h1);
    check("ds_redirect_flush", 32'(ifid_flush_o), 32'h1);
    tick();
    sample();
    check("ds_state_run", 32'(state_o), 32'h2);
    check("ds_cnt", 32'(stall_cnt_o), 32'h6);
    check("ds_pend_cleared", pc_next_o, 32'h3C8);
    tick();

    // Long icache stall: CNT_W=4 instance saturates
    icache_stall_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    icache_stall_i = 1'b0; pc_i = 32'hFFFF_FFFC;
    sample();
    check("sat_cnt4", 32'(s_stall_cnt_o), 32'hF);
    check("sat_cnt16", 32'(stall_cnt_o), 32'd26);
    check("wrap_pc_next", pc_next_o, 32'h0);
    check("wrap_pc_en", 32'(pc_enable_o), 32'h1);
    tick();
    sample();
    check("sat_state_run", 32'(state_o), 32'h2);
    tick();

    // Halt while WAIT has a pending redirect
    pc_i = 32'h600; dcache_stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h777;
    tick();
    branch_taken_i = 1'b0; start_i = 1'b0;
    sample();
    check("halt_pc_en", 32'(pc_enable_o), 32'h0);
    check("halt_stall", 32'(stall_o), 32'h0);
    check("halt_pc_next", pc_next_o, 32'h0);
    check("halt_bubble", 32'(idex_bubble_o), 32'h1);
    tick();
    dcache_stall_i = 1'b0;
    sample();
    check("halt_state", 32'(state_o), 32'h0);
    check("halt_cnt", 32'(stall_cnt_o), 32'd27);
    tick();

    // Restart: boot again, no stale redirect afterwards
    start_i = 1'b1; pc_i = 32'h40;
    tick();
    sample();
    check("rs_state_boot", 32'(state_o), 32'h1);
    tick();
    tick();
    sample();
    check("rs_state_run", 32'(state_o), 32'h2);
    check("rs_pc_next", pc_next_o, 32'h44);
    check("rs_flush", 32'(ifid_flush_o), 32'h0);
    check("rs_cnt", 32'(stall_cnt_o), 32'd27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
